// File: rtl/vram_write_ctrl.sv
// Framed-command write sequencer for the VRAM user port: parses SYNC/CMD/ADDR/LEN frames from
// uart_rx bytes and issues WRITE-burst or FILL writes with a wrapping address pointer.
module vram_write_ctrl #(
    parameter int          ADDR_W         = 15,
    parameter int          DATA_W         = 6,
    parameter int          VRAM_DEPTH     = 30000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 1066667
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_rx_ack,
    output logic              o_vram_we,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [DATA_W-1:0] o_vram_data,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_err
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_ONE   = {{(TMO_W-1){1'b0}}, 1'b1};
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       CMD_WRITE = 8'h01;
    localparam logic [7:0]       CMD_FILL  = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_AH, S_AL, S_LH, S_LL, S_DATA, S_VAL, S_FILL
    } state_t;

    state_t             r_state, w_state;
    logic [7:0]         r_cmd, w_cmd;
    logic [7:0]         r_addr_hi, w_addr_hi;
    logic [7:0]         r_len_hi, w_len_hi;
    logic [ADDR_W-1:0]  r_addr, w_addr;
    logic [15:0]        r_len, w_len;
    logic [DATA_W-1:0]  r_val, w_val;
    logic [TMO_W-1:0]   r_tmo, w_tmo;
    logic               r_rx_ack;
    logic               r_we, w_we;
    logic [ADDR_W-1:0]  r_vaddr, w_vaddr;
    logic [DATA_W-1:0]  r_vdata, w_vdata;
    logic               r_done, w_done;
    logic               r_err, w_err;
    logic               w_accept;
    logic               w_timed;
    logic [15:0]        w_byte16;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        if (a == ADDR_W'(VRAM_DEPTH - 1)) begin
            return {ADDR_W{1'b0}};
        end else begin
            return a + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Frame parser and write sequencer: next-state and next registered outputs
    always_comb begin
        w_state   = r_state;
        w_cmd     = r_cmd;
        w_addr_hi = r_addr_hi;
        w_len_hi  = r_len_hi;
        w_addr    = r_addr;
        w_len     = r_len;
        w_val     = r_val;
        w_tmo     = r_tmo;
        w_we      = 1'b0;
        w_vaddr   = r_vaddr;
        w_vdata   = r_vdata;
        w_done    = 1'b0;
        w_err     = 1'b0;
        w_accept  = i_rx_valid && !r_rx_ack && (r_state != S_FILL);
        w_timed   = (r_state != S_IDLE) && (r_state != S_FILL);
        w_byte16  = 16'h0000;

        if (!w_timed) begin
            w_tmo = {TMO_W{1'b0}};
        end else if (w_accept) begin
            w_tmo = {TMO_W{1'b0}};
        end else begin
            w_tmo = r_tmo + TMO_ONE;
        end

        case (r_state)
            S_IDLE: begin
                if (w_accept && (i_rx_data == SYNC_BYTE)) begin
                    w_state = S_CMD;
                end else begin
                    w_state = S_IDLE;
                end
            end
            S_CMD: begin
                if (!w_accept) begin
                    w_state = S_CMD;
                end else if ((i_rx_data == CMD_WRITE) || (i_rx_data == CMD_FILL)) begin
                    w_cmd   = i_rx_data;
                    w_state = S_AH;
                end else begin
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end
            end
            S_AH: begin
                if (w_accept) begin
                    w_addr_hi = i_rx_data;
                    w_state   = S_AL;
                end else begin
                    w_state   = S_AH;
                end
            end
            S_AL: begin
                w_byte16 = {r_addr_hi, i_rx_data};
                if (!w_accept) begin
                    w_state = S_AL;
                end else if ({16'h0000, w_byte16} >= 32'(VRAM_DEPTH)) begin
                    w_err   = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_addr  = w_byte16[ADDR_W-1:0];
                    w_state = S_LH;
                end
            end
            S_LH: begin
                if (w_accept) begin
                    w_len_hi = i_rx_data;
                    w_state  = S_LL;
                end else begin
                    w_state  = S_LH;
                end
            end
            S_LL: begin
                w_byte16 = {r_len_hi, i_rx_data};
                if (!w_accept) begin
                    w_state = S_LL;
                end else if (w_byte16 == 16'h0000) begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else if (r_cmd == CMD_WRITE) begin
                    w_len   = w_byte16;
                    w_state = S_DATA;
                end else begin
                    w_len   = w_byte16;
                    w_state = S_VAL;
                end
            end
            // DATA and VAL both write on the consuming edge; VAL then hands over to FILL
            S_DATA, S_VAL: begin
                if (w_accept) begin
                    w_we    = 1'b1;
                    w_vaddr = r_addr;
                    w_vdata = i_rx_data[DATA_W-1:0];
                    w_val   = i_rx_data[DATA_W-1:0];
                    w_addr  = next_addr(r_addr);
                    w_len   = r_len - 16'd1;
                    if (r_len == 16'd1) begin
                        w_done  = 1'b1;
                        w_state = S_IDLE;
                    end else if (r_state == S_VAL) begin
                        w_state = S_FILL;
                    end else begin
                        w_state = S_DATA;
                    end
                end else begin
                    w_state = r_state;
                end
            end
            S_FILL: begin
                w_we    = 1'b1;
                w_vaddr = r_addr;
                w_vdata = r_val;
                w_addr  = next_addr(r_addr);
                w_len   = r_len - 16'd1;
                if (r_len == 16'd1) begin
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_state = S_FILL;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        if (w_timed && !w_accept && (r_tmo == TMO_LAST)) begin
            w_state = S_IDLE;
            w_err   = 1'b1;
            w_tmo   = {TMO_W{1'b0}};
        end else begin
            w_tmo   = w_tmo;
        end
    end

    // State and registered-output update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cmd     <= 8'h00;
            r_addr_hi <= 8'h00;
            r_len_hi  <= 8'h00;
            r_addr    <= {ADDR_W{1'b0}};
            r_len     <= 16'h0000;
            r_val     <= {DATA_W{1'b0}};
            r_tmo     <= {TMO_W{1'b0}};
            r_rx_ack  <= 1'b0;
            r_we      <= 1'b0;
            r_vaddr   <= {ADDR_W{1'b0}};
            r_vdata   <= {DATA_W{1'b0}};
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state;
            r_cmd     <= w_cmd;
            r_addr_hi <= w_addr_hi;
            r_len_hi  <= w_len_hi;
            r_addr    <= w_addr;
            r_len     <= w_len;
            r_val     <= w_val;
            r_tmo     <= w_tmo;
            r_rx_ack  <= w_accept;
            r_we      <= w_we;
            r_vaddr   <= w_vaddr;
            r_vdata   <= w_vdata;
            r_done    <= w_done;
            r_err     <= w_err;
        end
    end

    assign o_rx_ack     = r_rx_ack;
    assign o_vram_we    = r_we;
    assign o_vram_addr  = r_vaddr;
    assign o_vram_data  = r_vdata;
    assign o_busy       = (r_state != S_IDLE);
    assign o_frame_done = r_done;
    assign o_err        = r_err;

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Scoreboard bench for vram_write_ctrl: frames are turned into expected write/done/err events
// by a frame-level model; a negedge monitor pops and compares whatever the DUT presents.
module tb_vram_write_ctrl;

    localparam int DEPTH = 30000;
    localparam int TMO   = 100;
    localparam int K_W   = 0;
    localparam int K_D   = 1;
    localparam int K_E   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ack, o_vram_we, o_busy, o_frame_done, o_err;
    logic [14:0] o_vram_addr;
    logic [5:0]  o_vram_data;

    typedef struct {
        int kind;
        int addr;
        int data;
        bit last;
        bit consec;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pay_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int prev_wr_cyc = -10;
    int writes_seen = 0;
    int err_cyc  = 0;
    int last_ack_cyc = 0;

    vram_write_ctrl #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_rx_ack(o_rx_ack), .o_vram_we(o_vram_we), .o_vram_addr(o_vram_addr),
        .o_vram_data(o_vram_data), .o_busy(o_busy), .o_frame_done(o_frame_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int k, input int a, input int d, input bit l, input bit c);
        ev_t e;
        e.kind = k; e.addr = a; e.data = d; e.last = l; e.consec = c;
        exp_q.push_back(e);
    endtask

    // Monitor: every DUT write/done/err is matched against the head of the expected queue
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (!rst && (o_vram_we || o_frame_done || o_err)) begin
            chk("err_done_exclusive", int'(o_err && o_frame_done), 0);
            k = o_vram_we ? K_W : (o_err ? K_E : K_D);
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_event: got kind %0d addr %0d data %0d, expected none",
                         k, o_vram_addr, o_vram_data);
            end else begin
                n_pass++;
                e = exp_q.pop_front();
                chk("event_kind", k, e.kind);
                if (e.kind == K_W && k == K_W) begin
                    chk("wr_addr", int'(o_vram_addr), e.addr);
                    chk("wr_data", int'(o_vram_data), e.data);
                    chk("wr_done_flag", int'(o_frame_done), int'(e.last));
                    if (e.consec) chk("fill_consecutive", cyc, prev_wr_cyc + 1);
                end
            end
            if (o_vram_we) begin
                prev_wr_cyc = cyc;
                writes_seen++;
            end
            if (o_err) err_cyc = cyc;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t;
        @(negedge clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        t = 0;
        while (!o_rx_ack && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!o_rx_ack) $display("FAIL rx_ack_timeout: byte %02h not acknowledged", b);
        @(posedge clk);
        #1 i_rx_valid = 1'b0;
        last_ack_cyc = cyc;
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    task automatic send_hdr(input logic [7:0] c, input int a, input int len);
        send_byte(8'hA5);
        send_byte(c);
        send_byte(8'((a >> 8) & 255));
        send_byte(8'(a & 255));
        send_byte(8'((len >> 8) & 255));
        send_byte(8'(len & 255));
    endtask

    task automatic do_write(input int a, input int len);
        logic [7:0] d[$];
        for (int i = 0; i < len; i++) begin
            d.push_back((i < pay_q.size()) ? pay_q[i] : 8'($urandom));
            push(K_W, (a + i) % DEPTH, int'(d[i]) % 64, i == len - 1, 1'b0);
        end
        if (len == 0) push(K_D, 0, 0, 1'b1, 1'b0);
        pay_q.delete();
        send_hdr(8'h01, a, len);
        foreach (d[i]) send_byte(d[i]);
    endtask

    task automatic do_fill(input int a, input int len, input logic [7:0] v);
        for (int i = 0; i < len; i++) push(K_W, (a + i) % DEPTH, int'(v) % 64, i == len - 1, i > 0);
        if (len == 0) push(K_D, 0, 0, 1'b1, 1'b0);
        send_hdr(8'h02, a, len);
        if (len != 0) send_byte(v);
    endtask

    function automatic logic [7:0] non_sync();
        logic [7:0] b;
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        return b;
    endfunction

    task automatic do_badaddr(input int a);
        push(K_E, 0, 0, 1'b0, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'((a >> 8) & 255));
        send_byte(8'(a & 255));
        repeat (3) send_byte(non_sync());
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || o_busy) && t < 20000) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_drained"}, exp_q.size(), 0);
        chk({name, "_busy"}, int'(o_busy), 0);
    endtask

    initial begin
        int base, t, sel, a;
        logic [7:0] c;

        repeat (3) @(negedge clk);
        chk("reset_outputs", int'({o_rx_ack, o_vram_we, o_vram_addr, o_vram_data,
                                  o_busy, o_frame_done, o_err}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        pay_q = '{8'h11, 8'h22, 8'h3F};
        do_write(16, 3);
        wait_idle("t1_write");

        do_fill(29998, 4, 8'h2A);
        wait_idle("t2_fill_wrap");

        do_badaddr(30000);
        wait_idle("t3_badaddr");
        pay_q = '{8'h05};
        do_write(100, 1);
        wait_idle("t3_recover");

        send_byte(8'h00);
        send_byte(8'hFF);
        push(K_E, 0, 0, 1'b0, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h07);
        wait_idle("t4_garbage");

        push(K_E, 0, 0, 1'b0, 1'b0);
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        wait_idle("t5_timeout");
        n_checks++;
        if (err_cyc - last_ack_cyc >= TMO - 10 && err_cyc - last_ack_cyc <= TMO + 10) n_pass++;
        else $display("FAIL t5_timeout_delay: got %0d cycles expected about %0d",
                      err_cyc - last_ack_cyc, TMO);

        do_fill(0, 20, 8'h3A);
        wait_idle("fill_len20");

        for (int n = 0; n < 40; n++) begin
            sel = $urandom_range(0, 5);
            a = ($urandom_range(0, 1) == 1) ? $urandom_range(0, DEPTH - 1)
                                            : $urandom_range(DEPTH - 10, DEPTH - 1);
            case (sel)
                0, 1: do_write(a, $urandom_range(0, 6));
                2:    do_fill(a, $urandom_range(0, 40), 8'($urandom));
                3:    do_badaddr($urandom_range(DEPTH, 65535));
                4: begin
                    c = 8'($urandom_range(3, 255));
                    push(K_E, 0, 0, 1'b0, 1'b0);
                    send_byte(8'hA5);
                    send_byte(c);
                end
                default: repeat (2) send_byte(non_sync());
            endcase
            wait_idle("rand_frame");
        end

        base = writes_seen;
        do_fill(500, 1000, 8'h15);
        t = 0;
        while (writes_seen < base + 10 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        chk("t6_reached_write10", int'(writes_seen >= base + 10), 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_we_dropped", int'(o_vram_we), 0);
        chk("t6_busy_dropped", int'(o_busy), 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        chk("t6_no_write_in_reset", int'(o_vram_we), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pay_q = '{8'h11, 8'h22, 8'h3F};
        do_write(16, 3);
        wait_idle("t6_recover");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
